cy_tx_arbiter: RTL and testbench
================================

# cy_tx_arbiter

Parametrised N-source packet arbiter and writer for the Cypress slave-FIFO IN endpoint. It collects complete messages from any number of SPI/UART capture channels, selects among them round-robin, and frames each one as a header, payload and optional checksum. It writes the frame to FD with SLWR and commits it with PKTEND. It sits between the per-channel `spi_process`/`uart_process` instances and the Cypress pins, replacing the fixed-count write path in the slave-FIFO controller.

## Interface
Parameters:
- NUM_SRC, 8, number of source channels; legal range 1–256.
- EP_ADDR, 2'b10, FIFOADR value driven for the IN endpoint.
- GAP_CYCLES, 2, idle cycles inserted after PKTEND before the next arbitration; legal range 0–15.

Ports:
- CLK, in, 1, system clock; all logic is on this single clock.
- RST, in, 1, asynchronous active-high reset.
- GOT_FULL_MSG, in, NUM_SRC, per-source flag: a complete message is buffered.
- MSG_LEN_BUS, in, NUM_SRC*8, per-source payload length in 16-bit words; source i occupies bits [8i+7:8i].
- FIFO_Q_BUS, in, NUM_SRC*16, per-source FIFO output; source i occupies bits [16i+15:16i]; data is valid 1 cycle after RD_REQ.
- RD_REQ, out, NUM_SRC, per-source FIFO read strobe, one-hot or zero.
- MSG_START, out, NUM_SRC, one-cycle grant pulse to the selected source.
- FLAG_FULL, in, 1, Cypress full flag, active-low (0 = endpoint full).
- FD_OUT, out, 16, write data in big-endian word order; byte swap is done at the top level.
- FD_OE, out, 1, FD output enable.
- SLWR, out, 1, slave write strobe, active-low.
- PKTEND, out, 1, packet commit strobe, active-low.
- FIFOADR, out, 2, constant EP_ADDR.
- BUSY, out, 1, high from grant until the end of the gap.

## Operation
- States:
  - IDLE: arbitration; exits when any GOT_FULL_MSG is high.
  - HDR: write the header word.
  - PAY: move payload words.
  - SUM: write the checksum word (macro builds only).
  - END: assert PKTEND.
  - GAP: count GAP_CYCLES idle cycles, then return to IDLE.
- Arbitration is round-robin. The search starts at last_grant+1 and wraps modulo NUM_SRC; last_grant resets to NUM_SRC-1, so source 0 wins first.
- On grant:
  - MSG_START[sel] pulses for 1 cycle.
  - MSG_LEN for the selected source is latched into len_cnt.
  - The state moves to HDR.
- Header word is {sel[7:0], len[7:0]}. It is written when FLAG_FULL=1, otherwise it is held in HDR.
- PAY, issue side:
  - RD_REQ[sel] is asserted in a cycle only when all of these hold: FLAG_FULL=1, the skid register is empty, and words issued < len.
  - A returned word goes to FD with SLWR=0 if FLAG_FULL=1. Otherwise it goes into the 1-word skid register, which drains first once FLAG_FULL=1.
- PAY ends after len words have been written. len=0 skips PAY entirely, giving a header-only packet.
- END: PKTEND=0 for exactly 1 cycle; SLWR stays high in that cycle.
- GOT_FULL_MSG changes while not in IDLE are ignored.
- A source deasserting GOT_FULL_MSG mid-packet has no effect; the latched len governs the transfer.

## Timing
- Reset values: RD_REQ=0, MSG_START=0, FD_OUT=0, FD_OE=0, SLWR=1, PKTEND=1, BUSY=0, FIFOADR=EP_ADDR, state=IDLE, skid empty.
- Reset asserted mid-packet:
  - All outputs return to their reset values immediately.
  - The partial packet is not committed.
  - last_grant is also reset.
- Cycle sequence for one packet, with FLAG_FULL held at 1:
  - Grant at cycle T.
  - Header SLWR at T+1.
  - First RD_REQ at T+1.
  - First payload SLWR at T+2; payload writes are back-to-back.
  - Last payload write at T+1+len.
  - PKTEND at T+2+len, or T+3+len with checksum.
- FD_OE is high from HDR through END inclusive.
- FD_OUT is valid on every cycle where SLWR=0.
- FLAG_FULL falling:
  - The in-flight word goes to the skid register.
  - No SLWR is issued while FLAG_FULL=0.
  - No data is lost or duplicated.

## Configuration
- CY_TX_CHECKSUM_EN defined:
  - SUM state is present.
  - A trailer word is written after the payload, equal to the 16-bit XOR of the header and all payload words.
  - The trailer obeys the same FLAG_FULL stall rule as other words.
- Undefined: PAY goes directly to END and the frame is header plus payload only.

## Structure
- Shared package `cy_tx_pkg` holds:
  - the state enum;
  - header field positions HDR_ID_MSB/LSB and HDR_LEN_MSB/LSB;
  - the WORD_W=16 and LEN_W=8 constants.
- One sub-module, `rr_arbiter`: parametrised by NUM_SRC, taking a request vector and a last-grant index, and returning a one-hot grant plus its index, combinationally.

## Test plan
- Single source 3 with len=4 and payload 0x1111..0x4444, FLAG_FULL=1 → writes 0x0304, 0x1111, 0x2222, 0x3333, 0x4444, then PKTEND 1 cycle later.
- Sources 0, 1 and 5 all requesting → grants in order 0, 1, 5, then 0 again if still requesting; GAP_CYCLES idle cycles between each PKTEND and the next MSG_START.
- len=6 with FLAG_FULL=0 for 3 cycles after the second payload write → exactly 6 payload writes in order, none while FLAG_FULL=0, skid register exercised.
- len=0 on source 7 → header 0x0700 followed directly by PKTEND; RD_REQ is never asserted.
- CY_TX_CHECKSUM_EN with header 0x0102 and payload 0x00FF, 0x0F00 → trailer 0x0EFD.
- RST asserted in PAY after 2 of 5 words → SLWR=1 and PKTEND=1 immediately; after release, source 0 has first priority.

Source files
------------

// File: rtl/cy_tx_pkg.sv
// rtl/cy_tx_pkg.sv - shared states, header layout and widths for the Cypress IN-endpoint packet writer
package cy_tx_pkg;

    localparam int WORD_W = 16;
    localparam int LEN_W  = 8;

    localparam int HDR_ID_MSB  = 15;
    localparam int HDR_ID_LSB  = 8;
    localparam int HDR_LEN_MSB = 7;
    localparam int HDR_LEN_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_SUM,
        ST_END,
        ST_GAP
    } tx_state_e;

    function automatic logic [WORD_W-1:0] make_hdr(input logic [7:0] id, input logic [LEN_W-1:0] len);
        logic [WORD_W-1:0] h;
        h = '0;
        h[HDR_ID_MSB:HDR_ID_LSB]   = id;
        h[HDR_LEN_MSB:HDR_LEN_LSB] = len;
        return h;
    endfunction

endpackage

// File: rtl/cy_tx_arbiter_rr.sv
// rtl/cy_tx_arbiter_rr.sv - combinational round-robin picker (module rr_arbiter), search starts after last_grant
module rr_arbiter #(
    parameter int NUM_SRC = 8,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   last_grant,
    output logic [NUM_SRC-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               grant_vld
);

    always_comb begin
        int cand;
        logic [IDX_W-1:0] ci;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        cand      = 0;
        ci        = '0;
        // i runs 1..NUM_SRC so last_grant itself is checked last
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand = int'(last_grant) + i;
            if (cand >= NUM_SRC) cand = cand - NUM_SRC;
            ci = IDX_W'(cand);
            if (!grant_vld && req[ci]) begin
                grant_vld = 1'b1;
                grant[ci] = 1'b1;
                grant_idx = ci;
            end
        end
    end

endmodule

// File: rtl/cy_tx_arbiter.sv
// rtl/cy_tx_arbiter.sv - N-source packet arbiter/writer for the slave-FIFO IN endpoint; CY_TX_CHECKSUM_EN adds an XOR trailer
module cy_tx_arbiter
    import cy_tx_pkg::*;
#(
    parameter int         NUM_SRC    = 8,
    parameter logic [1:0] EP_ADDR    = 2'b10,
    parameter int         GAP_CYCLES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [NUM_SRC-1:0]    GOT_FULL_MSG,
    input  logic [NUM_SRC*8-1:0]  MSG_LEN_BUS,
    input  logic [NUM_SRC*16-1:0] FIFO_Q_BUS,
    output logic [NUM_SRC-1:0]    RD_REQ,
    output logic [NUM_SRC-1:0]    MSG_START,
    input  logic                  FLAG_FULL,
    output logic [15:0]           FD_OUT,
    output logic                  FD_OE,
    output logic                  SLWR,
    output logic                  PKTEND,
    output logic [1:0]            FIFOADR,
    output logic                  BUSY
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
`ifdef CY_TX_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    tx_state_e          state_q, state_d;
    logic [IDX_W-1:0]   last_grant_q, sel_q, arb_idx;
    logic [NUM_SRC-1:0] arb_grant;
    logic               arb_vld;
    logic [LEN_W-1:0]   len_q, issued_q, written_q;
    logic               rd_pend_q, skid_vld_q;
    logic [WORD_W-1:0]  skid_q, csum_q;
    logic [3:0]         gap_q;

    logic [WORD_W-1:0]  fifo_word, hdr_word, wr_word;
    logic               do_grant, do_write, do_issue;

    rr_arbiter #(.NUM_SRC(NUM_SRC), .IDX_W(IDX_W)) u_rr (
        .req        (GOT_FULL_MSG),
        .last_grant (last_grant_q),
        .grant      (arb_grant),
        .grant_idx  (arb_idx),
        .grant_vld  (arb_vld)
    );

    assign fifo_word = FIFO_Q_BUS[sel_q*WORD_W +: WORD_W];
    assign hdr_word  = make_hdr(8'(sel_q), len_q);
    assign FIFOADR   = EP_ADDR;
    assign FD_OUT    = wr_word;
    assign SLWR      = ~do_write;
    assign RD_REQ    = do_issue ? (NUM_SRC'(1) << sel_q) : '0;
    assign MSG_START = do_grant ? arb_grant : '0;

    always_comb begin
        state_d  = state_q;
        do_grant = 1'b0;
        do_write = 1'b0;
        do_issue = 1'b0;
        wr_word  = '0;
        FD_OE    = 1'b0;
        PKTEND   = 1'b1;
        BUSY     = (state_q != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                // RST gate keeps the grant pulse quiet while reset holds state in IDLE
                if (arb_vld && !RST) begin
                    do_grant = 1'b1;
                    BUSY     = 1'b1;
                    state_d  = ST_HDR;
                end
            end
            ST_HDR: begin
                FD_OE   = 1'b1;
                wr_word = hdr_word;
                if (FLAG_FULL) begin
                    do_write = 1'b1;
                    do_issue = (len_q != '0);
                    if (len_q == '0) state_d = CSUM_EN ? ST_SUM : ST_END;
                    else             state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                FD_OE   = 1'b1;
                wr_word = skid_vld_q ? skid_q : fifo_word;
                if (FLAG_FULL) begin
                    do_write = skid_vld_q || rd_pend_q;
                    do_issue = !skid_vld_q && (issued_q != len_q);
                    if (do_write && (written_q == len_q - LEN_W'(1)))
                        state_d = CSUM_EN ? ST_SUM : ST_END;
                end
            end
            ST_SUM: begin
                FD_OE   = 1'b1;
                wr_word = csum_q;
                if (FLAG_FULL) begin
                    do_write = 1'b1;
                    state_d  = ST_END;
                end
            end
            ST_END: begin
                FD_OE   = 1'b1;
                PKTEND  = 1'b0;
                state_d = (GAP_CYCLES == 0) ? ST_IDLE : ST_GAP;
            end
            ST_GAP: begin
                if (gap_q == 4'(GAP_CYCLES - 1)) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            last_grant_q <= IDX_W'(NUM_SRC - 1);
            sel_q        <= '0;
            len_q        <= '0;
            issued_q     <= '0;
            written_q    <= '0;
            rd_pend_q    <= 1'b0;
            skid_vld_q   <= 1'b0;
            skid_q       <= '0;
            csum_q       <= '0;
            gap_q        <= '0;
        end else begin
            state_q   <= state_d;
            rd_pend_q <= do_issue;
            if (do_grant) begin
                sel_q        <= arb_idx;
                last_grant_q <= arb_idx;
                len_q        <= MSG_LEN_BUS[arb_idx*LEN_W +: LEN_W];
                issued_q     <= '0;
                written_q    <= '0;
                skid_vld_q   <= 1'b0;
            end
            if (do_issue) issued_q <= issued_q + 1'b1;
            if (state_q == ST_PAY) begin
                if (do_write) written_q <= written_q + 1'b1;
                // a word returning into a stalled endpoint parks here; it always drains before the next read
                if (FLAG_FULL) begin
                    skid_vld_q <= 1'b0;
                end else if (rd_pend_q) begin
                    skid_vld_q <= 1'b1;
                    skid_q     <= fifo_word;
                end
            end
            if (do_write && state_q == ST_HDR)      csum_q <= hdr_word;
            else if (do_write && state_q == ST_PAY) csum_q <= csum_q ^ wr_word;
            if (state_q == ST_END)      gap_q <= '0;
            else if (state_q == ST_GAP) gap_q <= gap_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_cy_tx_arbiter.sv
// tb/tb_cy_tx_arbiter.sv - self-checking bench for cy_tx_arbiter with a word scoreboard and FIFO source model
module tb_cy_tx_arbiter;

    localparam int NS  = 8;
    localparam int GAP = 2;
`ifdef CY_TX_CHECKSUM_EN
    localparam int CS = 1;
`else
    localparam int CS = 0;
`endif

    logic            CLK, RST, FLAG_FULL;
    logic [NS-1:0]   GOT_FULL_MSG, RD_REQ, MSG_START;
    logic [NS*8-1:0] MSG_LEN_BUS;
    logic [NS*16-1:0] FIFO_Q_BUS;
    logic [15:0]     FD_OUT;
    logic            FD_OE, SLWR, PKTEND, BUSY;
    logic [1:0]      FIFOADR;

    cy_tx_arbiter #(.NUM_SRC(NS), .EP_ADDR(2'b10), .GAP_CYCLES(GAP)) dut (
        .CLK(CLK), .RST(RST), .GOT_FULL_MSG(GOT_FULL_MSG), .MSG_LEN_BUS(MSG_LEN_BUS),
        .FIFO_Q_BUS(FIFO_Q_BUS), .RD_REQ(RD_REQ), .MSG_START(MSG_START), .FLAG_FULL(FLAG_FULL),
        .FD_OUT(FD_OUT), .FD_OE(FD_OE), .SLWR(SLWR), .PKTEND(PKTEND), .FIFOADR(FIFOADR), .BUSY(BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // source FIFO model: rewinds on grant, returns a word the cycle after RD_REQ
    logic [15:0] mem [NS][16];
    logic [15:0] q [NS];
    int          rd_ptr [NS];

    always @(posedge CLK) begin
        for (int i = 0; i < NS; i++) begin
            if (RST || MSG_START[i]) rd_ptr[i] <= 0;
            else if (RD_REQ[i]) begin
                q[i]      <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 1;
            end
        end
    end

    always_comb begin
        FIFO_Q_BUS = '0;
        for (int i = 0; i < NS; i++) FIFO_Q_BUS[i*16 +: 16] = q[i];
    end

    // scoreboard: bit16 set marks the expected PKTEND
    logic [16:0] exp_q [$];
    logic [7:0]  gnt_log [$];
    int          gnt_cyc [$];
    int          pkt_cyc [$];
    int          cyc = 0, rdreq_cnt = 0, wr_cnt = 0;
    logic [15:0] last_word = '0;

    always @(negedge CLK) begin
        logic [16:0] e;
        cyc++;
        if (!RST) begin
            if (|MSG_START) begin
                gnt_log.push_back(MSG_START);
                gnt_cyc.push_back(cyc);
                rdreq_cnt = 0;
                wr_cnt    = 0;
            end
            if (|RD_REQ) rdreq_cnt++;
            if (!SLWR) begin
                wr_cnt++;
                last_word = FD_OUT;
                check("slwr_while_full", {31'd0, FLAG_FULL}, 32'd1);
                if (exp_q.size() == 0) check("unexpected_write", {16'd0, FD_OUT}, 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    check("fd_word", {15'd0, 1'b0, FD_OUT}, {15'd0, e});
                end
            end
            if (!PKTEND) begin
                pkt_cyc.push_back(cyc);
                check("pktend_slwr_high", {31'd0, SLWR}, 32'd1);
                if (exp_q.size() == 0) check("unexpected_pktend", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("pktend_order", {15'd0, 1'b1, 16'h0000}, {15'd0, e});
                end
            end
        end
    end

    task automatic clear_logs();
        gnt_log.delete();
        gnt_cyc.delete();
        pkt_cyc.delete();
    endtask

    task automatic send_setup(input int src, input int len, input logic [15:0] base,
                              input logic [15:0] step, input logic [15:0] hdr);
        logic [15:0] w, cs;
        cs = hdr;
        exp_q.push_back({1'b0, hdr});
        for (int k = 0; k < len; k++) begin
            w = base + 16'(k) * step;
            mem[src][k] = w;
            cs = cs ^ w;
            exp_q.push_back({1'b0, w});
        end
`ifdef CY_TX_CHECKSUM_EN
        exp_q.push_back({1'b0, cs});
`endif
        exp_q.push_back(17'h10000);
        MSG_LEN_BUS[src*8 +: 8] = 8'(len);
    endtask

    task automatic wait_grants(input int n, input int bound);
        int c;
        c = 0;
        while (gnt_log.size() < n && c < bound) begin
            @(posedge CLK);
            c++;
        end
        check("grant_wait", 32'(gnt_log.size() >= n), 32'd1);
    endtask

    task automatic wait_pkts(input int n, input int bound);
        int c;
        c = 0;
        while (pkt_cyc.size() < n && c < bound) begin
            @(posedge CLK);
            c++;
        end
        check("pktend_wait", 32'(pkt_cyc.size() >= n), 32'd1);
    endtask

    task automatic wait_writes(input int n, input int bound);
        int c;
        c = 0;
        while (wr_cnt < n && c < bound) begin
            @(posedge CLK);
            c++;
        end
        check("write_wait", 32'(wr_cnt >= n), 32'd1);
    endtask

    typedef struct {
        int          src;
        int          len;
        logic [15:0] base;
        logic [15:0] hdr;
        logic [7:0]  start;
    } vec_t;

    vec_t tbl [4];
    logic [7:0] rr_exp [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{src: 3, len: 4, base: 16'h1111, hdr: 16'h0304, start: 8'h08};
        tbl[1] = '{src: 7, len: 0, base: 16'h0000, hdr: 16'h0700, start: 8'h80};
        tbl[2] = '{src: 2, len: 3, base: 16'h2000, hdr: 16'h0203, start: 8'h04};
        tbl[3] = '{src: 6, len: 1, base: 16'hBEEF, hdr: 16'h0601, start: 8'h40};
        rr_exp[0] = 8'h01; rr_exp[1] = 8'h02; rr_exp[2] = 8'h20; rr_exp[3] = 8'h01;
        for (int i = 0; i < NS; i++) for (int k = 0; k < 16; k++) mem[i][k] = 16'h0;

        // reset state, with every source requesting
        RST = 1'b1; FLAG_FULL = 1'b1; MSG_LEN_BUS = '0; GOT_FULL_MSG = 8'hFF;
        @(negedge CLK);
        check("rst_rd_req", {24'd0, RD_REQ}, 32'd0);
        check("rst_msg_start", {24'd0, MSG_START}, 32'd0);
        check("rst_outputs", {16'd0, FD_OUT}, 32'd0);
        check("rst_strobes", {28'd0, FD_OE, SLWR, PKTEND, BUSY}, 32'b0110);
        check("rst_fifoadr", {30'd0, FIFOADR}, 32'd2);
        GOT_FULL_MSG = '0;
        @(posedge CLK); #1 RST = 1'b0;

        // single-source packets, including header-only
        for (int r = 0; r < 4; r++) begin
            clear_logs();
            send_setup(tbl[r].src, tbl[r].len, tbl[r].base, 16'h1111, tbl[r].hdr);
            @(posedge CLK); #1 GOT_FULL_MSG[tbl[r].src] = 1'b1;
            wait_grants(1, 20);
            #1 GOT_FULL_MSG = '0;
            check("busy_in_packet", {31'd0, BUSY}, 32'd1);
            if (gnt_log.size() > 0) check("grant_vec", {24'd0, gnt_log[0]}, {24'd0, tbl[r].start});
            wait_pkts(1, 60);
            if (pkt_cyc.size() > 0 && gnt_cyc.size() > 0)
                check("pkt_latency", 32'(pkt_cyc[0] - gnt_cyc[0]), 32'(tbl[r].len + 2 + CS));
            check("rd_req_count", 32'(rdreq_cnt), 32'(tbl[r].len));
            repeat (GAP + 2) @(posedge CLK);
            #1 check("busy_after_gap", {31'd0, BUSY}, 32'd0);
            check("sb_empty", 32'(exp_q.size()), 32'd0);
        end

        // round-robin among 0, 1, 5
        clear_logs();
        send_setup(0, 1, 16'h0A0A, 16'h0, 16'h0001);
        send_setup(1, 1, 16'h1B1B, 16'h0, 16'h0101);
        send_setup(5, 1, 16'h5C5C, 16'h0, 16'h0501);
        send_setup(0, 1, 16'h0A0A, 16'h0, 16'h0001);
        @(posedge CLK); #1 GOT_FULL_MSG = 8'h23;
        wait_grants(4, 200);
        #1 GOT_FULL_MSG = '0;
        wait_pkts(4, 100);
        for (int i = 0; i < 4; i++)
            if (gnt_log.size() > i) check("rr_order", {24'd0, gnt_log[i]}, {24'd0, rr_exp[i]});
        for (int i = 0; i < 3; i++)
            if (pkt_cyc.size() > i && gnt_cyc.size() > i + 1)
                check("rr_gap", 32'(gnt_cyc[i+1] - pkt_cyc[i]), 32'(GAP + 1));
        repeat (GAP + 2) @(posedge CLK);

        // endpoint stall after the second payload word
        clear_logs();
        send_setup(4, 6, 16'h4000, 16'h0101, 16'h0406);
        @(posedge CLK); #1 GOT_FULL_MSG = 8'h10;
        wait_grants(1, 20);
        #1 GOT_FULL_MSG = '0;
        wait_writes(3, 20);
        #1 FLAG_FULL = 1'b0;
        repeat (3) @(posedge CLK);
        #1 FLAG_FULL = 1'b1;
        wait_pkts(1, 60);
        if (pkt_cyc.size() > 0 && gnt_cyc.size() > 0)
            check("stall_latency", 32'(pkt_cyc[0] - gnt_cyc[0]), 32'(6 + 2 + 4 + CS));
        check("stall_rd_req_count", 32'(rdreq_cnt), 32'd6);
        check("stall_sb_empty", 32'(exp_q.size()), 32'd0);
        repeat (GAP + 2) @(posedge CLK);

`ifdef CY_TX_CHECKSUM_EN
        clear_logs();
        send_setup(1, 2, 16'h00FF, 16'h0E01, 16'h0102);
        @(posedge CLK); #1 GOT_FULL_MSG = 8'h02;
        wait_grants(1, 20);
        #1 GOT_FULL_MSG = '0;
        wait_pkts(1, 40);
        check("checksum_trailer", {16'd0, last_word}, 32'h0000_0EFD);
        repeat (GAP + 2) @(posedge CLK);
`endif

        // reset mid-payload
        clear_logs();
        send_setup(2, 5, 16'h7000, 16'h0010, 16'h0205);
        @(posedge CLK); #1 GOT_FULL_MSG = 8'h04;
        wait_grants(1, 20);
        #1 GOT_FULL_MSG = '0;
        wait_writes(3, 20);
        #1 RST = 1'b1;
        #1 check("rst_mid_strobes", {28'd0, SLWR, PKTEND, FD_OE, BUSY}, 32'b1100);
        check("rst_mid_rd_req", {24'd0, RD_REQ}, 32'd0);
        exp_q.delete();
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        repeat (6) @(posedge CLK);
        check("rst_no_commit", 32'(pkt_cyc.size()), 32'd0);

        clear_logs();
        send_setup(0, 1, 16'hC0C0, 16'h0, 16'h0001);
        send_setup(3, 1, 16'hD3D3, 16'h0, 16'h0301);
        @(posedge CLK); #1 GOT_FULL_MSG = 8'h09;
        wait_grants(1, 20);
        #1 GOT_FULL_MSG = 8'h08;
        if (gnt_log.size() > 0) check("post_rst_first", {24'd0, gnt_log[0]}, 32'h01);
        wait_grants(2, 40);
        #1 GOT_FULL_MSG = '0;
        if (gnt_log.size() > 1) check("post_rst_second", {24'd0, gnt_log[1]}, 32'h08);
        wait_pkts(2, 60);
        repeat (GAP + 2) @(posedge CLK);
        check("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
